// File: rtl/redirect_pkg.sv
// rtl/redirect_pkg.sv - shared codes, flush indices and redirect kinds for redirect_ctrl
package redirect_pkg;

    localparam logic [1:0] SEL_SEQ  = 2'd0;
    localparam logic [1:0] SEL_BR   = 2'd1;
    localparam logic [1:0] SEL_JAL  = 2'd2;
    localparam logic [1:0] SEL_JALR = 2'd3;

    localparam int FL_IF_ID = 0;
    localparam int FL_ID_EX = 1;

    typedef enum logic [1:0] {
        RK_NONE = 2'd0,
        RK_BR   = 2'd1,
        RK_JAL  = 2'd2,
        RK_JALR = 2'd3
    } redirect_kind_e;

    // Larger value wins; EX-resolved kinds outrank the ID-decoded JAL.
    function automatic logic [1:0] kind_prio(input redirect_kind_e k);
        case (k)
            RK_BR:   kind_prio = 2'd3;
            RK_JALR: kind_prio = 2'd2;
            RK_JAL:  kind_prio = 2'd1;
            default: kind_prio = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/redirect_ctrl_flush_shadow_cnt.sv
// rtl/redirect_ctrl_flush_shadow_cnt.sv - loadable down-counter timing the wrong-path fetch shadow
module flush_shadow_cnt #(
    parameter int FETCH_LAT = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic hold,
    output logic busy
);

    localparam int W = (FETCH_LAT > 1) ? $clog2(FETCH_LAT) : 1;

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= W'(FETCH_LAT - 1);
        end else if (!hold && count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign busy = (count != '0);

endmodule

// File: rtl/redirect_ctrl.sv
// rtl/redirect_ctrl.sv - redirect arbitration, stall deferral and flush control; REDIRECT_PERF_EN adds counters
module redirect_ctrl
    import redirect_pkg::*;
#(
    parameter int PC_SEL_W   = 3,
    parameter int NUM_STAGES = 4,
    parameter int FETCH_LAT  = 1,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pipe_stall,
    input  logic                  br_taken,
    input  logic                  jalr,
    input  logic                  jal,
    output logic [PC_SEL_W-1:0]   pc_sel,
    output logic [NUM_STAGES-1:0] flush,
    output logic                  redirect_valid,
    output logic                  pending,
    output logic                  shadow_busy
`ifdef REDIRECT_PERF_EN
    ,
    output logic [CNT_W-1:0]      br_cnt,
    output logic [CNT_W-1:0]      jal_cnt,
    output logic [CNT_W-1:0]      jalr_cnt
`endif
);

    redirect_kind_e pend_q;
    redirect_kind_e pend_d;
    redirect_kind_e req_kind;
    redirect_kind_e apply_kind;
    logic [1:0]     sel_code;

    always_comb begin
        req_kind = RK_NONE;
        if (br_taken) begin
            req_kind = RK_BR;
        end else if (jalr) begin
            req_kind = RK_JALR;
        end else if (jal) begin
            req_kind = RK_JAL;
        end
    end

    // A stalled cycle only updates the held kind; the first free cycle applies
    // whichever of held/new ranks higher and the loser is dropped.
    always_comb begin
        pend_d     = pend_q;
        apply_kind = RK_NONE;
        if (pipe_stall) begin
            if (kind_prio(req_kind) > kind_prio(pend_q)) begin
                pend_d = req_kind;
            end
        end else begin
            apply_kind = (kind_prio(req_kind) >= kind_prio(pend_q)) ? req_kind : pend_q;
            pend_d     = RK_NONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= RK_NONE;
        end else begin
            pend_q <= pend_d;
        end
    end

    always_comb begin
        sel_code = SEL_SEQ;
        flush    = '0;
        case (apply_kind)
            RK_BR: begin
                sel_code           = SEL_BR;
                flush[FL_IF_ID]    = 1'b1;
                flush[FL_ID_EX]    = 1'b1;
            end
            RK_JALR: begin
                sel_code           = SEL_JALR;
                flush[FL_IF_ID]    = 1'b1;
                flush[FL_ID_EX]    = 1'b1;
            end
            RK_JAL: begin
                sel_code           = SEL_JAL;
                flush[FL_IF_ID]    = 1'b1;
            end
            default: begin
                sel_code           = SEL_SEQ;
            end
        endcase
        if (shadow_busy && !pipe_stall) begin
            flush[FL_IF_ID] = 1'b1;
        end
    end

    assign pc_sel         = PC_SEL_W'(sel_code);
    assign redirect_valid = (apply_kind != RK_NONE);
    assign pending        = (pend_q != RK_NONE);

    flush_shadow_cnt #(
        .FETCH_LAT (FETCH_LAT)
    ) u_shadow (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (redirect_valid),
        .hold  (pipe_stall),
        .busy  (shadow_busy)
    );

`ifdef REDIRECT_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_cnt   <= '0;
            jal_cnt  <= '0;
            jalr_cnt <= '0;
        end else begin
            if (apply_kind == RK_BR && br_cnt != '1) begin
                br_cnt <= br_cnt + 1'b1;
            end
            if (apply_kind == RK_JAL && jal_cnt != '1) begin
                jal_cnt <= jal_cnt + 1'b1;
            end
            if (apply_kind == RK_JALR && jalr_cnt != '1) begin
                jalr_cnt <= jalr_cnt + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_redirect_ctrl.sv
// tb/tb_redirect_ctrl.sv - scoreboard bench for redirect_ctrl at FETCH_LAT=1 and FETCH_LAT=4
module tb_redirect_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic pipe_stall = 1'b0;
    logic br_taken = 1'b0;
    logic jalr = 1'b0;
    logic jal = 1'b0;

    logic [2:0] pc_sel_a, pc_sel_b;
    logic [3:0] flush_a, flush_b;
    logic       rv_a, rv_b, pend_a, pend_b, sb_a, sb_b;
`ifdef REDIRECT_PERF_EN
    logic [15:0] brc_a, jc_a, jrc_a, brc_b, jc_b, jrc_b;
`endif

    always #5 clk = ~clk;

    redirect_ctrl #(.PC_SEL_W(3), .NUM_STAGES(4), .FETCH_LAT(1), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .pipe_stall(pipe_stall),
        .br_taken(br_taken), .jalr(jalr), .jal(jal),
        .pc_sel(pc_sel_a), .flush(flush_a), .redirect_valid(rv_a),
        .pending(pend_a), .shadow_busy(sb_a)
`ifdef REDIRECT_PERF_EN
        , .br_cnt(brc_a), .jal_cnt(jc_a), .jalr_cnt(jrc_a)
`endif
    );

    redirect_ctrl #(.PC_SEL_W(3), .NUM_STAGES(4), .FETCH_LAT(4), .CNT_W(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .pipe_stall(pipe_stall),
        .br_taken(br_taken), .jalr(jalr), .jal(jal),
        .pc_sel(pc_sel_b), .flush(flush_b), .redirect_valid(rv_b),
        .pending(pend_b), .shadow_busy(sb_b)
`ifdef REDIRECT_PERF_EN
        , .br_cnt(brc_b), .jal_cnt(jc_b), .jalr_cnt(jrc_b)
`endif
    );

    typedef struct {
        int sel;
        int fl_a;
        int fl_b;
        int rv;
        int pe;
        int sb_a;
        int sb_b;
        int cb;
        int cj;
        int cr;
    } exp_t;

    exp_t exp_q[$];

    int total = 0;
    int bad = 0;

    // model state: pending code (0 none, 1 br, 2 jal, 3 jalr), shadows, counters
    int m_pend = 0;
    int m_sh_a = 0;
    int m_sh_b = 0;
    int m_cb = 0;
    int m_cj = 0;
    int m_cr = 0;

    task automatic check_val(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int prio(input int code);
        case (code)
            1:       return 3;
            3:       return 2;
            2:       return 1;
            default: return 0;
        endcase
    endfunction

    task automatic compare_front();
        exp_t e;
        if (exp_q.size() == 0) begin
            check_val("queue_empty", 0, 1);
            return;
        end
        e = exp_q.pop_front();
        check_val("pc_sel_a", int'(pc_sel_a), e.sel);
        check_val("pc_sel_b", int'(pc_sel_b), e.sel);
        check_val("flush_a", int'(flush_a), e.fl_a);
        check_val("flush_b", int'(flush_b), e.fl_b);
        check_val("rv_a", int'(rv_a), e.rv);
        check_val("rv_b", int'(rv_b), e.rv);
        check_val("pending_a", int'(pend_a), e.pe);
        check_val("pending_b", int'(pend_b), e.pe);
        check_val("shadow_a", int'(sb_a), e.sb_a);
        check_val("shadow_b", int'(sb_b), e.sb_b);
`ifdef REDIRECT_PERF_EN
        check_val("br_cnt_a", int'(brc_a), e.cb);
        check_val("jal_cnt_a", int'(jc_a), e.cj);
        check_val("jalr_cnt_a", int'(jrc_a), e.cr);
        check_val("br_cnt_b", int'(brc_b), e.cb);
        check_val("jal_cnt_b", int'(jc_b), e.cj);
        check_val("jalr_cnt_b", int'(jrc_b), e.cr);
`endif
    endtask

    // Called just after a rising edge: drive one cycle, predict, compare at negedge.
    task automatic step(input bit s, input bit b, input bit r, input bit j);
        exp_t e;
        int req;
        int win;
        int base;
        pipe_stall = s;
        br_taken   = b;
        jalr       = r;
        jal        = j;
        req = b ? 1 : (r ? 3 : (j ? 2 : 0));
        win = 0;
        if (!s) win = (prio(req) >= prio(m_pend)) ? req : m_pend;
        base = (win == 1 || win == 3) ? 3 : ((win == 2) ? 1 : 0);
        e.sel  = win;
        e.rv   = (win != 0) ? 1 : 0;
        e.fl_a = base | ((!s && m_sh_a != 0) ? 1 : 0);
        e.fl_b = base | ((!s && m_sh_b != 0) ? 1 : 0);
        e.pe   = (m_pend != 0) ? 1 : 0;
        e.sb_a = (m_sh_a != 0) ? 1 : 0;
        e.sb_b = (m_sh_b != 0) ? 1 : 0;
        e.cb   = m_cb;
        e.cj   = m_cj;
        e.cr   = m_cr;
        exp_q.push_back(e);

        if (s) begin
            if (prio(req) > prio(m_pend)) m_pend = req;
        end else begin
            m_pend = 0;
        end
        if (win != 0) begin
            m_sh_a = 0;
            m_sh_b = 3;
        end else if (!s) begin
            if (m_sh_a > 0) m_sh_a--;
            if (m_sh_b > 0) m_sh_b--;
        end
        if (win == 1 && m_cb < 65535) m_cb++;
        if (win == 2 && m_cj < 65535) m_cj++;
        if (win == 3 && m_cr < 65535) m_cr++;

        @(negedge clk);
        compare_front();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_pc_sel_a"}, int'(pc_sel_a), 0);
        check_val({tag, "_pc_sel_b"}, int'(pc_sel_b), 0);
        check_val({tag, "_flush_a"}, int'(flush_a), 0);
        check_val({tag, "_flush_b"}, int'(flush_b), 0);
        check_val({tag, "_rv"}, int'(rv_a | rv_b), 0);
        check_val({tag, "_pending"}, int'(pend_a | pend_b), 0);
        check_val({tag, "_shadow"}, int'(sb_a | sb_b), 0);
`ifdef REDIRECT_PERF_EN
        check_val({tag, "_cnt"}, int'(brc_a | jc_a | jrc_a | brc_b | jc_b | jrc_b), 0);
`endif
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // unstalled branch, then sequential / shadow tail
        step(1'b0, 1'b1, 1'b0, 1'b0);
        idle(5);

        // jal with br_taken: branch wins
        step(1'b0, 1'b1, 1'b0, 1'b1);
        idle(5);

        // jalr in first of three stall cycles, applied on release
        step(1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        idle(5);

        // pending JAL replaced by branch while stalled
        step(1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        idle(5);

        // pending branch is not replaced by a lower-priority jalr
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        idle(5);

        // release cycle collisions: held JALR beats new JAL, new branch beats held JAL
        step(1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        idle(5);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        idle(5);

        // shadow with a stall inside it
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        idle(4);

        // shadow reload by a second redirect
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        idle(5);

        // random mix
        for (int i = 0; i < 60; i++) begin
            step(($urandom_range(0, 2) == 0), ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 4) == 0), ($urandom_range(0, 3) == 0));
        end
        idle(5);

        // reset mid-shadow with a redirect pending
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check_val("pre_reset_pending", int'(pend_b), 1);
        check_val("pre_reset_shadow", int'(sb_b), 1);
        pipe_stall = 1'b0;
        br_taken   = 1'b0;
        jalr       = 1'b0;
        jal        = 1'b0;
        rst_n      = 1'b0;
        #1;
        check_all_zero("async_reset");
        m_pend = 0;
        m_sh_a = 0;
        m_sh_b = 0;
        m_cb   = 0;
        m_cj   = 0;
        m_cr   = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        idle(6);

        check_val("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
